pixel_addr_divider: RTL

Sequential unsigned divider that converts a linear pixel address back into (row, column) coordinates: quotient = address / line_width, remainder = address % line_width. It sits in the frame-buffer read path, where a linear address generated by the multiply-add address datapath must be decomposed again for the display/scan side. It uses one radix-2 restoring step per cycle with a valid/ready handshake on both sides.

---
 rtl/pixel_addr_divider_pkg.sv | 14 +
 rtl/pixel_addr_divider_if.sv | 42 ++++
 rtl/pixel_addr_divider.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/pixel_addr_divider_pkg.sv
// Shared constants and FSM state type for the pixel address divider.
package pixel_addr_pkg;

  localparam int PIX_DIVIDEND_W = 21;
  localparam int PIX_DIVISOR_W  = 11;
  localparam int PIX_CNT_W      = $clog2(PIX_DIVIDEND_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/pixel_addr_divider_if.sv
// Operand/result handshake bundle for pixel_addr_divider.
// PIXEL_ADDR_DIV_ZERO_FLAG_EN adds the div_zero result flag.
interface pixel_addr_divider_if
  import pixel_addr_pkg::*;
#(
  parameter int DIVIDEND_W = PIX_DIVIDEND_W,
  parameter int DIVISOR_W  = PIX_DIVISOR_W
) ();

  logic                  in_valid;
  logic                  in_ready;
  logic [DIVIDEND_W-1:0] addr;
  logic [DIVISOR_W-1:0]  width;
  logic                  out_valid;
  logic                  out_ready;
  logic [DIVIDEND_W-1:0] row;
  logic [DIVISOR_W-1:0]  col;
`ifdef PIXEL_ADDR_DIV_ZERO_FLAG_EN
  logic                  div_zero;

  modport master (
    output in_valid, addr, width, out_ready,
    input  in_ready, out_valid, row, col, div_zero
  );

  modport slave (
    input  in_valid, addr, width, out_ready,
    output in_ready, out_valid, row, col, div_zero
  );
`else
  modport master (
    output in_valid, addr, width, out_ready,
    input  in_ready, out_valid, row, col
  );

  modport slave (
    input  in_valid, addr, width, out_ready,
    output in_ready, out_valid, row, col
  );
`endif

endinterface

// File: rtl/pixel_addr_divider.sv
// Radix-2 restoring divider: row = addr / width, col = addr % width, one bit per cycle.
// PIXEL_ADDR_DIV_ZERO_FLAG_EN: width==0 bypasses CALC and reports div_zero.
module pixel_addr_divider
  import pixel_addr_pkg::*;
#(
  parameter int DIVIDEND_W = PIX_DIVIDEND_W,
  parameter int DIVISOR_W  = PIX_DIVISOR_W
) (
  input  logic                clk,
  input  logic                reset,
  pixel_addr_divider_if.slave bus
);

  localparam int CNT_W = $clog2(DIVIDEND_W);

  div_state_e            r_state;
  div_state_e            w_next_state;
  logic [DIVIDEND_W-1:0] r_dividend;
  logic [DIVISOR_W-1:0]  r_divisor;
  logic [DIVISOR_W:0]    r_rem;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_in_ready;
  logic                  r_out_valid;

  logic                  w_in_fire;
  logic                  w_out_fire;
  logic                  w_width_zero;
  logic                  w_cnt_zero;
  logic [DIVISOR_W:0]    w_shift;
  logic [DIVISOR_W+1:0]  w_diff;
  logic                  w_negative;
  logic                  w_unused_rem_msb;

  assign w_in_fire    = bus.in_valid && (r_state == IDLE);
  assign w_out_fire   = bus.out_ready && (r_state == DONE);
  assign w_width_zero = (bus.width == {DIVISOR_W{1'b0}});
  assign w_cnt_zero   = (r_cnt == {CNT_W{1'b0}});

  // The remainder stays below the divisor, so its top bit never feeds the next step.
  assign w_shift          = {r_rem[DIVISOR_W-1:0], r_dividend[DIVIDEND_W-1]};
  assign w_diff           = {1'b0, w_shift} - {2'b00, r_divisor};
  assign w_negative       = w_diff[DIVISOR_W+1];
  assign w_unused_rem_msb = r_rem[DIVISOR_W];

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_in_fire) begin
`ifdef PIXEL_ADDR_DIV_ZERO_FLAG_EN
          if (w_width_zero) begin
            w_next_state = DONE;
          end else begin
            w_next_state = CALC;
          end
`else
          w_next_state = CALC;
`endif
        end else begin
          w_next_state = IDLE;
        end
      end
      CALC: begin
        if (w_cnt_zero) begin
          w_next_state = DONE;
        end else begin
          w_next_state = CALC;
        end
      end
      DONE: begin
        if (w_out_fire) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = DONE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Operand capture and one restoring step per CALC cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_dividend <= {DIVIDEND_W{1'b0}};
      r_divisor  <= {DIVISOR_W{1'b0}};
      r_rem      <= {(DIVISOR_W+1){1'b0}};
      r_cnt      <= {CNT_W{1'b0}};
    end else begin
      case (r_state)
        IDLE: begin
          if (w_in_fire) begin
            r_divisor <= bus.width;
            r_rem     <= {(DIVISOR_W+1){1'b0}};
            r_cnt     <= CNT_W'(DIVIDEND_W - 1);
`ifdef PIXEL_ADDR_DIV_ZERO_FLAG_EN
            r_dividend <= w_width_zero ? {DIVIDEND_W{1'b0}} : bus.addr;
`else
            r_dividend <= bus.addr;
`endif
          end
        end
        CALC: begin
          r_rem      <= w_negative ? w_shift : w_diff[DIVISOR_W:0];
          r_dividend <= {r_dividend[DIVIDEND_W-2:0], ~w_negative};
          if (!w_cnt_zero) begin
            r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Handshake flags registered from the next state
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_in_ready  <= (w_next_state == IDLE);
      r_out_valid <= (w_next_state == DONE);
    end
  end

`ifdef PIXEL_ADDR_DIV_ZERO_FLAG_EN
  logic r_div_zero;

  // Zero-divisor flag lives from acceptance until the result is consumed
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_div_zero <= 1'b0;
    end else if (w_in_fire) begin
      r_div_zero <= w_width_zero;
    end else if (w_out_fire) begin
      r_div_zero <= 1'b0;
    end else begin
      r_div_zero <= r_div_zero;
    end
  end

  assign bus.div_zero = r_div_zero;
`endif

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.row       = r_dividend;
  assign bus.col       = r_rem[DIVISOR_W-1:0];

endmodule
